iir_mac_filter: RTL and testbench
=================================

// Module: iir_mac_filter
// PURPOSE
//  Parametrised direct-form-I IIR filter, any order, time-multiplexed on a single signed MAC.
//  Streams samples from a sample memory (RAddr/load/DIn) and writes results back (WAddr/WEN/Yn).
//  Coefficients are runtime-programmable, not hard-coded. A start/Finish handshake frames each run.
// PARAMETERS
//  DATA_W  16  sample/result width, signed
//  COEF_W  20  coefficient width, signed, FRAC_W fraction bits
//  FRAC_W  16  coefficient fraction bits (1.0 = 1<<FRAC_W)
//  ORDER   5   filter order N: a0..aN feed-forward, b1..bN feedback
//  ADDR_W  20  sample/result memory address width
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       synchronous reset, active-high
//  start      in   1       begin a run at address 0; accepted only in IDLE or DONE
//  coef_we    in   1       coefficient write strobe; honoured only in IDLE or DONE
//  coef_sel   in   1       0 = a-bank, 1 = b-bank
//  coef_idx   in   clog2(ORDER+1)  tap index; b-bank index 0 ignored
//  coef_data  in   COEF_W  coefficient value
//  load       out  1       sample-memory read enable
//  RAddr      out  ADDR_W  sample read address
//  DIn        in   DATA_W  sample data, valid in the same cycle as load
//  data_done  in   1       high with load: current address holds no sample, end of stream
//  WEN        out  1       result write strobe, one cycle per sample
//  WAddr      out  ADDR_W  result write address (= sample index)
//  Yn         out  DATA_W  result data, valid while WEN=1
//  busy       out  1       high in READ/MAC/WRITE
//  Finish     out  1       run finished; sticky until start or rst
// BEHAVIOUR
//  Reset: state IDLE; RAddr, WAddr, Yn = 0; load, WEN, busy, Finish = 0; x/y history and all coefs = 0.
//  y[n] = sum(k=0..N) a_k*x[n-k] - sum(k=1..N) b_k*y[n-k]; history before sample 0 is zero.
//  FSM: IDLE -start-> READ -> MAC -> WRITE -> READ (next n) ... ; READ -data_done-> DONE; DONE -start-> READ.
//  READ (1 cycle): load=1, RAddr=n; DIn captured into x[n]; data_done=1 -> no capture, go DONE, Finish=1 next cycle.
//  MAC (2N+1 cycles): one product per cycle, order a0..aN then b1..bN; accumulator ACC_W bits, cleared at MAC entry.
//  WRITE (1 cycle): WEN=1, WAddr=n, Yn=acc>>>FRAC_W (arithmetic, truncate toward -inf); shift x/y history; n++.
//  Per-sample period 2N+3 cycles (13 at ORDER=5); WEN spacing exactly 2N+3.
//  start in IDLE/DONE clears history and Finish, n=0; start while busy ignored.
//  coef_we while busy ignored; coef_we with start in same cycle: write lands, new value used by the run.
//  RAddr at 2^ADDR_W-1: sample processed and written, then DONE as if data_done.
//  rst mid-run: everything returns to reset values next cycle, coefficients included.
//  Accumulator never overflows: ACC_W = DATA_W+COEF_W+clog2(2N+1).
// CONFIGURATION
//  SATURATE_EN defined: Yn clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; fed-back y[n] is the clamped value.
//  SATURATE_EN undefined: Yn = acc[FRAC_W+DATA_W-1:FRAC_W], two's-complement wrap.
// STRUCTURE
//  iir_pkg: FSM state enum, ACC_W/index-width functions, COEF_SEL_A/COEF_SEL_B constants.
//  Sub-module iir_mac_unit: signed DATA_W x COEF_W multiply, add/subtract select, clear, ACC_W accumulator.
//  Top holds FSM, tap counter, history shift registers, coefficient banks, output formatting.
// TESTING
//  1 rst held, then released -> all outputs 0, busy=0; coefs read back as zero response (Yn=0 for any DIn).
//  2 a0=0x10000 rest 0, DIn 0x4000,0,0 -> Yn 0x4000,0x0000,0x0000 at WAddr 0,1,2; WEN every 13 cycles.
//  3 a0=0x08000, b1=0xF8000 (-0.5), DIn 0x4000 x3 -> Yn 0x2000,0x3000,0x3800.
//  4 a0=0x20000, DIn 0x7000 -> Yn 0x7FFF with SATURATE_EN, 0xE000 without.
//  5 data_done high at RAddr=3 -> WEN only for 0..2, Finish=1 and held until start; start re-runs from 0.
//  6 rst pulsed mid-MAC of sample 1 -> outputs/coefs zero next cycle; reprogram + start gives test-3 results.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared types and sizing helpers for the time-multiplexed IIR filter.
package iir_pkg;

  // Filter sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_MAC   = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } iir_state_e;

  localparam logic COEF_SEL_A = 1'b0;
  localparam logic COEF_SEL_B = 1'b1;

  // Width of a coefficient tap index (0..order).
  function automatic int idx_w(input int order);
    return (order < 1) ? 1 : $clog2(order + 1);
  endfunction

  // Width of the MAC tap counter (0..2*order).
  function automatic int tap_w(input int order);
    return (order < 1) ? 1 : $clog2(2 * order + 1);
  endfunction

  // Accumulator width: one full product plus growth for 2N+1 terms.
  function automatic int acc_w(input int data_w, input int coef_w, input int order);
    return data_w + coef_w + tap_w(order);
  endfunction

endpackage

// File: rtl/iir_mac_unit.sv
// Signed multiply-accumulate datapath: one DATA_W x COEF_W product per cycle,
// added to or subtracted from an ACC_W accumulator; clr restarts the sum
// with the current product.
module iir_mac_unit #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 20,
  parameter int ACC_W  = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic                     clr_i,
  input  logic                     sub_i,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic signed [COEF_W-1:0] c_i,
  output logic signed [ACC_W-1:0]  acc_o
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  base;
  logic signed [ACC_W-1:0]  acc_q, acc_d;

  assign prod     = x_i * c_i;
  assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
  assign base     = clr_i ? '0 : acc_q;

  // Next accumulator value: add feed-forward terms, subtract feedback terms.
  always_comb begin
    acc_d = acc_q;
    if (en_i) begin
      acc_d = sub_i ? (base - prod_ext) : (base + prod_ext);
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/iir_mac_filter.sv
// Direct-form-I IIR filter of arbitrary order on a single shared MAC.
// Reads samples, runs 2N+1 MAC cycles, writes one result per sample.
// Build option: define SATURATE_EN to clamp results to the DATA_W range
// (the clamped value is also what gets fed back); otherwise results wrap.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | after reset, waiting for start; coefficients writable
// ST_READ  | load=1, fetch x[n] at RAddr=n, or end stream on data_done
// ST_MAC   | 2N+1 products: a0..aN on x history, then b1..bN on y history
// ST_WRITE | WEN=1, Yn at WAddr=n, shift histories, advance n
// ST_DONE  | run finished, Finish held; coefficients writable, start re-runs
module iir_mac_filter
  import iir_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 20,
  parameter int FRAC_W = 16,
  parameter int ORDER  = 5,
  parameter int ADDR_W = 20,
  localparam int IDX_W = idx_w(ORDER)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              coef_we,
  input  logic              coef_sel,
  input  logic [IDX_W-1:0]  coef_idx,
  input  logic [COEF_W-1:0] coef_data,
  output logic              load,
  output logic [ADDR_W-1:0] RAddr,
  input  logic [DATA_W-1:0] DIn,
  input  logic              data_done,
  output logic              WEN,
  output logic [ADDR_W-1:0] WAddr,
  output logic [DATA_W-1:0] Yn,
  output logic              busy,
  output logic              Finish
);

  localparam int TAP_W = tap_w(ORDER);
  localparam int ACC_W = acc_w(DATA_W, COEF_W, ORDER);
  localparam int HI_W  = ACC_W - FRAC_W;
  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(2 * ORDER);

  iir_state_e        state_q, state_d;
  logic [TAP_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] n_q, n_d;
  logic              fin_q, fin_d;

  logic signed [DATA_W-1:0] x_q [0:ORDER];
  logic signed [DATA_W-1:0] y_q [1:ORDER];
  logic signed [COEF_W-1:0] a_q [0:ORDER];
  logic signed [COEF_W-1:0] b_q [1:ORDER];

  logic                     idle_or_done;
  logic                     run_start;
  logic [TAP_W-1:0]         tap;
  logic signed [DATA_W-1:0] op_x;
  logic signed [COEF_W-1:0] op_c;
  logic                     op_sub;
  logic signed [ACC_W-1:0]  acc;
  logic signed [HI_W-1:0]   acc_hi;
  logic signed [DATA_W-1:0] y_fmt;

  assign idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign run_start    = start && idle_or_done;

  // Sequencer next state; the tap counter runs down from 2N to 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    fin_d   = fin_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_READ;
          n_d     = '0;
          fin_d   = 1'b0;
        end
      end
      ST_READ: begin
        if (data_done) begin
          state_d = ST_DONE;
          fin_d   = 1'b1;
        end else begin
          state_d = ST_MAC;
          cnt_d   = TAP_LAST;
        end
      end
      ST_MAC: begin
        if (cnt_q == '0) begin
          state_d = ST_WRITE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WRITE: begin
        // Last addressable sample ends the stream without wrapping.
        if (&n_q) begin
          state_d = ST_DONE;
          fin_d   = 1'b1;
        end else begin
          state_d = ST_READ;
          n_d     = n_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      fin_q   <= fin_d;
    end
  end

  // Coefficient banks; writable only while no run is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= ORDER; k++) a_q[k] <= '0;
      for (int k = 1; k <= ORDER; k++) b_q[k] <= '0;
    end else if (coef_we && idle_or_done) begin
      for (int k = 0; k <= ORDER; k++) begin
        if (coef_sel == COEF_SEL_A && coef_idx == IDX_W'(k)) a_q[k] <= coef_data;
      end
      for (int k = 1; k <= ORDER; k++) begin
        if (coef_sel == COEF_SEL_B && coef_idx == IDX_W'(k)) b_q[k] <= coef_data;
      end
    end
  end

  // Sample and result history: x[0] is the current sample, x[k]/y[k] are k samples back.
  always_ff @(posedge clk) begin
    if (rst || run_start) begin
      for (int k = 0; k <= ORDER; k++) x_q[k] <= '0;
      for (int k = 1; k <= ORDER; k++) y_q[k] <= '0;
    end else if (state_q == ST_READ && !data_done) begin
      x_q[0] <= DIn;
    end else if (state_q == ST_WRITE) begin
      for (int k = ORDER; k >= 1; k--) x_q[k] <= x_q[k-1];
      for (int k = ORDER; k >= 2; k--) y_q[k] <= y_q[k-1];
      y_q[1] <= y_fmt;
    end
  end

  assign tap = TAP_LAST - cnt_q;

  // Operand select for the current tap: 0..N feed-forward, N+1..2N feedback.
  always_comb begin
    op_x   = '0;
    op_c   = '0;
    op_sub = 1'b0;
    for (int k = 0; k <= ORDER; k++) begin
      if (tap == TAP_W'(k)) begin
        op_x = x_q[k];
        op_c = a_q[k];
      end
    end
    for (int k = 1; k <= ORDER; k++) begin
      if (tap == TAP_W'(ORDER + k)) begin
        op_x   = y_q[k];
        op_c   = b_q[k];
        op_sub = 1'b1;
      end
    end
  end

  iir_mac_unit #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .en_i  (state_q == ST_MAC),
    .clr_i ((state_q == ST_MAC) && (cnt_q == TAP_LAST)),
    .sub_i (op_sub),
    .x_i   (op_x),
    .c_i   (op_c),
    .acc_o (acc)
  );

  // Dropping the low FRAC_W bits is an arithmetic shift, i.e. truncation toward -inf.
  assign acc_hi = acc[ACC_W-1:FRAC_W];

`ifdef SATURATE_EN
  localparam logic signed [HI_W-1:0] HI_MAX = HI_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [HI_W-1:0] HI_MIN = ~HI_MAX;

  logic acc_unused;
  assign acc_unused = ^acc[FRAC_W-1:0];

  // Clamp the scaled sum to the representable result range.
  always_comb begin
    y_fmt = acc_hi[DATA_W-1:0];
    if (acc_hi > HI_MAX) begin
      y_fmt = {1'b0, {(DATA_W - 1){1'b1}}};
    end else if (acc_hi < HI_MIN) begin
      y_fmt = {1'b1, {(DATA_W - 1){1'b0}}};
    end
  end
`else
  logic acc_unused;
  assign acc_unused = ^{acc[FRAC_W-1:0], acc_hi[HI_W-1:DATA_W]};

  // Two's-complement wrap of the scaled sum.
  always_comb begin
    y_fmt = acc_hi[DATA_W-1:0];
  end
`endif

  assign load   = (state_q == ST_READ);
  assign RAddr  = n_q;
  assign WEN    = (state_q == ST_WRITE);
  assign WAddr  = n_q;
  assign Yn     = y_fmt;
  assign busy   = (state_q == ST_READ) || (state_q == ST_MAC) || (state_q == ST_WRITE);
  assign Finish = fin_q;

endmodule

// File: tb/tb_iir_mac_filter.sv
// Scoreboard bench for iir_mac_filter: expected results are queued when a
// run is launched and popped on every WEN. Honours SATURATE_EN.
module tb_iir_mac_filter;

  localparam int DATA_W = 16;
  localparam int COEF_W = 20;
  localparam int FRAC_W = 16;
  localparam int ORDER  = 5;
  localparam int ADDR_W = 4;
  localparam int IDX_W  = 3;
  localparam int PERIOD = 2 * ORDER + 3;
  localparam int MEM_N  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              coef_we;
  logic              coef_sel;
  logic [IDX_W-1:0]  coef_idx;
  logic [COEF_W-1:0] coef_data;
  logic              load;
  logic [ADDR_W-1:0] RAddr;
  logic [DATA_W-1:0] DIn;
  logic              data_done;
  logic              WEN;
  logic [ADDR_W-1:0] WAddr;
  logic [DATA_W-1:0] Yn;
  logic              busy;
  logic              Finish;

  logic [DATA_W-1:0] mem [0:MEM_N-1];
  int                stream_len;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   mon_e;
  int     n_checks = 0;
  int     n_errors = 0;
  int     cyc = 0;
  int     last_wen = -1;
  longint ca [0:ORDER];
  longint cb [0:ORDER];

  iir_mac_filter #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .FRAC_W (FRAC_W),
    .ORDER  (ORDER),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .coef_we   (coef_we),
    .coef_sel  (coef_sel),
    .coef_idx  (coef_idx),
    .coef_data (coef_data),
    .load      (load),
    .RAddr     (RAddr),
    .DIn       (DIn),
    .data_done (data_done),
    .WEN       (WEN),
    .WAddr     (WAddr),
    .Yn        (Yn),
    .busy      (busy),
    .Finish    (Finish)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign DIn       = mem[RAddr];
  assign data_done = (int'(RAddr) >= stream_len);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Output monitor: every WEN must match the head of the scoreboard, spaced PERIOD apart.
  always @(negedge clk) begin
    if (rst || start) begin
      last_wen = -1;
    end else if (WEN) begin
      if (exp_q.size() == 0) begin
        check_eq("wen_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("yn", 32'(Yn), 32'(mon_e.data));
        check_eq("waddr", 32'(WAddr), 32'(mon_e.addr));
      end
      if (last_wen >= 0) check_eq("wen_spacing", 32'(cyc - last_wen), 32'(PERIOD));
      last_wen = cyc;
    end
  end

  function automatic longint fmt_y(input longint hi);
    logic signed [DATA_W-1:0] t;
`ifdef SATURATE_EN
    if (hi > 32767) return 32767;
    if (hi < -32768) return -32768;
    return hi;
`else
    t = hi[DATA_W-1:0];
    return t;
`endif
  endfunction

  // Reference: y[n] = sum a_k x[n-k] - sum b_k y[n-k], scaled by 2^-FRAC_W.
  task automatic model_push(input int n);
    longint xh [0:ORDER];
    longint yh [0:ORDER];
    longint acc, y;
    logic signed [DATA_W-1:0] s;
    exp_t e;
    for (int k = 0; k <= ORDER; k++) begin xh[k] = 0; yh[k] = 0; end
    for (int i = 0; i < n; i++) begin
      for (int k = ORDER; k >= 1; k--) xh[k] = xh[k-1];
      s = mem[i];
      xh[0] = s;
      acc = 0;
      for (int k = 0; k <= ORDER; k++) acc += ca[k] * xh[k];
      for (int k = 1; k <= ORDER; k++) acc -= cb[k] * yh[k];
      y = fmt_y(acc >>> FRAC_W);
      e.addr = ADDR_W'(i);
      e.data = DATA_W'(y);
      exp_q.push_back(e);
      for (int k = ORDER; k >= 2; k--) yh[k] = yh[k-1];
      yh[1] = y;
    end
  endtask

  task automatic push_exp(input int addr, input logic [DATA_W-1:0] data);
    exp_t e;
    e.addr = ADDR_W'(addr);
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic set_shadow(input logic sel, input int idx, input logic [COEF_W-1:0] val);
    logic signed [COEF_W-1:0] sv;
    sv = val;
    if (sel == 1'b0) ca[idx] = sv;
    else if (idx >= 1) cb[idx] = sv;
  endtask

  task automatic prog(input logic sel, input int idx, input logic [COEF_W-1:0] val);
    @(posedge clk); #1;
    coef_we = 1'b1; coef_sel = sel; coef_idx = idx[IDX_W-1:0]; coef_data = val;
    @(posedge clk); #1;
    coef_we = 1'b0;
    set_shadow(sel, idx, val);
  endtask

  task automatic clear_coefs();
    for (int k = 0; k <= ORDER; k++) prog(1'b0, k, '0);
    for (int k = 1; k <= ORDER; k++) prog(1'b1, k, '0);
  endtask

  task automatic wait_finish(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (Finish) break;
    end
    check_eq("finish", 32'(Finish), 32'd1);
  endtask

  // Launch a run of n samples; optional coefficient write on the start cycle
  // and optional pokes (coef_we, start) while busy that must be ignored.
  task automatic run_stream(input int n, input bit use_model, input bit poke_busy,
                            input bit cw_en, input logic cw_sel, input int cw_idx,
                            input logic [COEF_W-1:0] cw_val);
    stream_len = n;
    if (cw_en) set_shadow(cw_sel, cw_idx, cw_val);
    if (use_model) model_push(n);
    @(posedge clk); #1;
    start = 1'b1;
    if (cw_en) begin
      coef_we = 1'b1; coef_sel = cw_sel; coef_idx = cw_idx[IDX_W-1:0]; coef_data = cw_val;
    end
    @(posedge clk); #1;
    start = 1'b0;
    coef_we = 1'b0;
    check_eq("run_load", 32'(load), 32'd1);
    check_eq("run_raddr0", 32'(RAddr), 32'd0);
    check_eq("run_busy", 32'(busy), 32'd1);
    check_eq("run_finish_clr", 32'(Finish), 32'd0);
    if (poke_busy) begin
      coef_we = 1'b1; coef_sel = 1'b0; coef_idx = '0; coef_data = 20'h7FFFF;
      @(posedge clk); #1;
      coef_we = 1'b0;
      repeat (4) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_finish(n * PERIOD + 30);
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    check_eq("done_busy", 32'(busy), 32'd0);
    check_eq("done_load", 32'(load), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_load"},   32'(load),   32'd0);
    check_eq({tag, "_raddr"},  32'(RAddr),  32'd0);
    check_eq({tag, "_wen"},    32'(WEN),    32'd0);
    check_eq({tag, "_waddr"},  32'(WAddr),  32'd0);
    check_eq({tag, "_yn"},     32'(Yn),     32'd0);
    check_eq({tag, "_busy"},   32'(busy),   32'd0);
    check_eq({tag, "_finish"}, 32'(Finish), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    int r;
    rst = 1'b1; start = 1'b0; coef_we = 1'b0; coef_sel = 1'b0;
    coef_idx = '0; coef_data = '0; stream_len = 0;
    for (int i = 0; i < MEM_N; i++) mem[i] = '0;
    for (int k = 0; k <= ORDER; k++) begin ca[k] = 0; cb[k] = 0; end

    // 1: reset state, then zero coefficients give zero output for any input.
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("rst");
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("post_rst");
    for (int i = 0; i < 3; i++) begin r = $urandom_range(1, 65535); mem[i] = r[15:0]; end
    push_exp(0, 16'h0000); push_exp(1, 16'h0000); push_exp(2, 16'h0000);
    run_stream(3, 0, 0, 0, 1'b0, 0, '0);

    // 2: unity pass-through.
    prog(1'b0, 0, 20'h10000);
    mem[0] = 16'h4000; mem[1] = 16'h0000; mem[2] = 16'h0000;
    push_exp(0, 16'h4000); push_exp(1, 16'h0000); push_exp(2, 16'h0000);
    run_stream(3, 0, 0, 0, 1'b0, 0, '0);

    // 3: first-order recursion, a0=0.5, b1=-0.5.
    prog(1'b0, 0, 20'h08000);
    prog(1'b1, 1, 20'hF8000);
    mem[0] = 16'h4000; mem[1] = 16'h4000; mem[2] = 16'h4000;
    push_exp(0, 16'h2000); push_exp(1, 16'h3000); push_exp(2, 16'h3800);
    run_stream(3, 0, 0, 0, 1'b0, 0, '0);

    // 5: Finish sticky while idle after end of stream.
    repeat (5) @(posedge clk);
    #1;
    check_eq("finish_sticky", 32'(Finish), 32'd1);
    check_eq("idle_wen", 32'(WEN), 32'd0);

    // 4: overflow of the result range.
    prog(1'b0, 0, 20'h20000);
    prog(1'b1, 1, 20'h00000);
    mem[0] = 16'h7000;
`ifdef SATURATE_EN
    push_exp(0, 16'h7FFF);
`else
    push_exp(0, 16'hE000);
`endif
    run_stream(1, 0, 0, 0, 1'b0, 0, '0);

    // 6: reset in the middle of sample 1's MAC phase.
    prog(1'b0, 0, 20'h08000);
    prog(1'b1, 1, 20'hF8000);
    mem[0] = 16'h4000; mem[1] = 16'h4000; mem[2] = 16'h4000;
    push_exp(0, 16'h2000);
    stream_len = 3;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (load && RAddr == 4'd1) break;
      @(posedge clk); #1;
    end
    check_eq("reach_s1_load", 32'(load), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("mid_mac_busy", 32'(busy), 32'd1);
    check_eq("mid_mac_sb", 32'(exp_q.size()), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    exp_q.delete();
    for (int k = 0; k <= ORDER; k++) begin ca[k] = 0; cb[k] = 0; end
    push_exp(0, 16'h0000);
    run_stream(1, 0, 0, 0, 1'b0, 0, '0);
    prog(1'b0, 0, 20'h08000);
    prog(1'b1, 1, 20'hF8000);
    push_exp(0, 16'h2000); push_exp(1, 16'h3000); push_exp(2, 16'h3800);
    run_stream(3, 0, 0, 0, 1'b0, 0, '0);

    // 7: random full-order filter, coef write with start, ignored pokes while busy.
    for (int k = 0; k <= ORDER; k++) begin
      r = int'($urandom_range(0, 65535)) - 32768;
      prog(1'b0, k, r[COEF_W-1:0]);
    end
    for (int k = 1; k <= ORDER; k++) begin
      r = int'($urandom_range(0, 16383)) - 8192;
      prog(1'b1, k, r[COEF_W-1:0]);
    end
    for (int i = 0; i < MEM_N; i++) begin r = $urandom_range(0, 65535); mem[i] = r[15:0]; end
    r = int'($urandom_range(0, 65535)) - 32768;
    run_stream(10, 1, 1, 1, 1'b0, 2, r[COEF_W-1:0]);

    // 8: stream reaching the last address with no data_done.
    for (int i = 0; i < MEM_N; i++) begin r = $urandom_range(0, 65535); mem[i] = r[15:0]; end
    run_stream(MEM_N, 1, 0, 0, 1'b0, 0, '0);
    check_eq("max_raddr", 32'(RAddr), 32'(MEM_N - 1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
